// File: rtl/ntt_pkg.sv
// Shared constants and coefficient type for the 4-point NTT over Z_257 (omega = 16).
// Also provides the single-subtraction input reduction used on raw 9-bit coefficients.
package ntt_pkg;
   localparam int COEF_W = 9;
   localparam int Q      = 257;
   localparam int OMEGA  = 16;
   localparam int N      = 4;

   typedef logic [COEF_W-1:0] coef_t;

   // Raw inputs span 0..511, so one conditional subtraction lands them in [0, 256].
   function automatic coef_t mod_reduce(input coef_t x);
      if (x >= coef_t'(Q))
         return x - coef_t'(Q);
      return x;
   endfunction
endpackage

// File: rtl/ntt_bfly.sv
// Radix-2 butterfly over Z_257: o_sum = x + w*y, o_diff = x - w*y, with w = 16 when i_mul16 else 1.
// Operands are assumed already reduced into [0, 256]; results stay in that range.
module ntt_bfly
   import ntt_pkg::*;
(
   input  coef_t i_x,
   input  coef_t i_y,
   input  logic  i_mul16,
   output coef_t o_sum,
   output coef_t o_diff
);
   logic [12:0] w_prod;
   logic [7:0]  w_lo;
   logic [4:0]  w_hi;
   coef_t       w_m16;
   coef_t       w_wy;
   logic [9:0]  w_sum_ext;

   // y*16 mod 257 using 2^8 = -1: low byte minus the bits above it.
   assign w_prod = {i_y, 4'b0000};
   assign w_lo   = w_prod[7:0];
   assign w_hi   = w_prod[12:8];
   // The borrow branch wraps mod 512 internally but the true result is below 257.
   assign w_m16  = ({1'b0, w_lo} >= {4'b0000, w_hi})
                 ? ({1'b0, w_lo} - {4'b0000, w_hi})
                 : ({1'b0, w_lo} + coef_t'(Q) - {4'b0000, w_hi});

   assign w_wy = i_mul16 ? w_m16 : i_y;

   assign w_sum_ext = {1'b0, i_x} + {1'b0, w_wy};
   assign o_sum     = (w_sum_ext >= 10'(Q)) ? coef_t'(w_sum_ext - 10'(Q)) : coef_t'(w_sum_ext);
   assign o_diff    = (i_x >= w_wy) ? (i_x - w_wy) : (i_x + coef_t'(Q) - w_wy);
endmodule

// File: rtl/ntt_4.sv
// 4-point forward NTT over Z_257, natural-order in and out, one result per clock.
// Define NTT4_PIPE_EN to register the first butterfly stage (latency 2 instead of 1).
module ntt_4
   import ntt_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [N*COEF_W-1:0] a,
   output logic                out_valid,
   output logic [N*COEF_W-1:0] an
);
   coef_t w_a [N];
   coef_t w_A [N];
   coef_t w_t0, w_t1, w_t2, w_d13;
   coef_t w_s2_t0, w_s2_t1, w_s2_t2, w_s2_d13;
   logic  w_s2_valid;
   logic [N*COEF_W-1:0] w_an_next;
   logic [N*COEF_W-1:0] r_an;
   logic                r_out_valid;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_reduce
         assign w_a[gi] = mod_reduce(a[gi*COEF_W +: COEF_W]);
      end
   endgenerate

   // Stage 1 keeps a1 - a3 un-twiddled; the x16 is folded into the odd stage-2 butterfly.
   ntt_bfly u_bf_02 (
      .i_x    (w_a[0]),
      .i_y    (w_a[2]),
      .i_mul16(1'b0),
      .o_sum  (w_t0),
      .o_diff (w_t1)
   );

   ntt_bfly u_bf_13 (
      .i_x    (w_a[1]),
      .i_y    (w_a[3]),
      .i_mul16(1'b0),
      .o_sum  (w_t2),
      .o_diff (w_d13)
   );

`ifdef NTT4_PIPE_EN
   coef_t r_t0, r_t1, r_t2, r_d13;
   logic  r_valid1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid1 <= 1'b0;
         r_t0     <= '0;
         r_t1     <= '0;
         r_t2     <= '0;
         r_d13    <= '0;
      end else begin
         r_valid1 <= in_valid;
         if (in_valid) begin
            r_t0  <= w_t0;
            r_t1  <= w_t1;
            r_t2  <= w_t2;
            r_d13 <= w_d13;
         end
      end
   end

   assign w_s2_t0    = r_t0;
   assign w_s2_t1    = r_t1;
   assign w_s2_t2    = r_t2;
   assign w_s2_d13   = r_d13;
   assign w_s2_valid = r_valid1;
`else
   assign w_s2_t0    = w_t0;
   assign w_s2_t1    = w_t1;
   assign w_s2_t2    = w_t2;
   assign w_s2_d13   = w_d13;
   assign w_s2_valid = in_valid;
`endif

   ntt_bfly u_bf_even (
      .i_x    (w_s2_t0),
      .i_y    (w_s2_t2),
      .i_mul16(1'b0),
      .o_sum  (w_A[0]),
      .o_diff (w_A[2])
   );

   ntt_bfly u_bf_odd (
      .i_x    (w_s2_t1),
      .i_y    (w_s2_d13),
      .i_mul16(1'b1),
      .o_sum  (w_A[1]),
      .o_diff (w_A[3])
   );

   generate
      for (gi = 0; gi < N; gi++) begin : g_pack
         assign w_an_next[gi*COEF_W +: COEF_W] = w_A[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_an        <= '0;
      end else begin
         r_out_valid <= w_s2_valid;
         if (w_s2_valid)
            r_an <= w_an_next;
      end
   end

   assign out_valid = r_out_valid;
   assign an        = r_an;
endmodule

// File: tb/tb_ntt_4.sv
// Bench for ntt_4: directed vectors, random streaming and reset-in-flight, checked against
// a direct-sum NTT model through an expected-result queue.
module tb_ntt_4;
`ifdef NTT4_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [35:0] a;
   logic        out_valid;
   logic [35:0] an;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [35:0] exp_q [$];
   logic [35:0] last_an;
   bit   [1:0]  vhist;

   always #5 clk = ~clk;

   ntt_4 dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .a        (a),
      .out_valid(out_valid),
      .an       (an)
   );

   // Direct evaluation of A_k = sum_j a_j * 16^(jk) mod 257.
   function automatic logic [35:0] model(input logic [35:0] x);
      int c [4];
      int w [4];
      int acc;
      logic [35:0] r;
      w[0] = 1; w[1] = 16; w[2] = 256; w[3] = 241;
      r = '0;
      for (int j = 0; j < 4; j++) c[j] = int'(x[9*j +: 9]) % 257;
      for (int k = 0; k < 4; k++) begin
         acc = 0;
         for (int j = 0; j < 4; j++) acc = (acc + c[j] * w[(j*k) % 4]) % 257;
         r[9*k +: 9] = 9'(acc);
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic cycle(input logic r, input logic v, input logic [35:0] x, input string tag);
      logic [35:0] e;
      @(negedge clk);
      rst      = r;
      in_valid = v;
      a        = x;
      @(posedge clk);
      #1;
      if (r) begin
         exp_q.delete();
         vhist   = '0;
         last_an = '0;
      end else begin
         vhist = {vhist[0], v};
         if (v) exp_q.push_back(model(x));
      end
      $display("t=%0t %s rst=%0b in_valid=%0b a=%h -> out_valid=%0b an=%h",
               $time, tag, r, v, x, out_valid, an);
      check($sformatf("%s.out_valid", tag), 36'(out_valid), 36'(vhist[LAT-1]));
      if (vhist[LAT-1]) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("%s.an", tag), an, e);
            last_an = e;
         end
      end else begin
         check($sformatf("%s.hold", tag), an, last_an);
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      last_an  = '0;
      vhist    = '0;

      cycle(1'b1, 1'b0, 36'h0, "reset0");
      cycle(1'b1, 1'b0, 36'h0, "reset1");

      cycle(1'b0, 1'b1, 36'h008040201, "all_ones");
      cycle(1'b0, 1'b1, 36'h000000001, "impulse");
      cycle(1'b0, 1'b1, 36'h000000200, "shift_imp");
      cycle(1'b0, 1'b1, {9'd256, 9'd256, 9'd256, 9'd256}, "max256");
      cycle(1'b0, 1'b1, {9'd257, 9'd257, 9'd257, 9'd257}, "unred257");
      cycle(1'b0, 1'b1, {9'd511, 9'd0, 9'd300, 9'd3}, "mixed");
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 36'(i * 7), "idle");

      for (int i = 0; i < 24; i++) cycle(1'b0, 1'b1, {4'($urandom), $urandom}, "stream");
      cycle(1'b0, 1'b0, 36'h0, "gap");
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'($urandom_range(0, 1)), {4'($urandom), $urandom}, "sparse");

      cycle(1'b0, 1'b1, {9'd5, 9'd6, 9'd7, 9'd8}, "pre_rst");
      cycle(1'b1, 1'b1, {9'd9, 9'd10, 9'd11, 9'd12}, "rst_in_flight");
      cycle(1'b0, 1'b1, {9'd100, 9'd200, 9'd300, 9'd400}, "post_rst");
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 36'h0, "drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
